// File: rtl/pump_bank_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pump_bank_ctrl_pkg
// Shared definitions for the sump pump bank controller.
//   pump_state_e : controller state encoding (IDLE=0, PUMP=1, SENS_ERR=2)
// -----------------------------------------------------------------------------
package pump_bank_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PUMP     = 2'd1,
        ST_SENS_ERR = 2'd2
    } pump_state_e;

endpackage : pump_bank_ctrl_pkg

// File: rtl/pump_bank_ctrl_pick.sv
// -----------------------------------------------------------------------------
// pump_pick
// Combinational round-robin selector. Starting at start_idx (inclusive) and
// walking upward modulo N_PUMPS, returns the first index i with mask[i]=1 and
// excl_mask[i]=0.
//   mask      in  N_PUMPS  candidate pumps (typically the healthy ones)
//   start_idx in  IDX_W    first index examined
//   excl_mask in  N_PUMPS  pumps that must not be returned
//   pick_idx  out IDX_W    selected index (0 when nothing qualifies)
//   pick_vld  out 1        a qualifying index was found
// -----------------------------------------------------------------------------
module pump_pick
    import pump_bank_ctrl_pkg::*;
#(
    parameter  int N_PUMPS = 2,
    localparam int IDX_W   = $clog2(N_PUMPS)
) (
    input  logic [N_PUMPS-1:0] mask,
    input  logic [IDX_W-1:0]   start_idx,
    input  logic [N_PUMPS-1:0] excl_mask,
    output logic [IDX_W-1:0]   pick_idx,
    output logic               pick_vld
);

    logic [IDX_W-1:0] pick_idx_s;
    logic             pick_vld_s;
    logic [IDX_W-1:0] cand_s;
    logic             take_s;

    // Scan the ring once from start_idx; the first qualifying index wins.
    always_comb begin
        pick_idx_s = {IDX_W{1'b0}};
        pick_vld_s = 1'b0;
        cand_s     = {IDX_W{1'b0}};
        take_s     = 1'b0;
        for (int k = 0; k < N_PUMPS; k++) begin
            cand_s     = IDX_W'((int'(start_idx) + k) % N_PUMPS);
            take_s     = ~pick_vld_s & mask[cand_s] & ~excl_mask[cand_s];
            pick_idx_s = take_s ? cand_s : pick_idx_s;
            pick_vld_s = pick_vld_s | take_s;
        end
    end

    assign pick_idx = pick_idx_s;
    assign pick_vld = pick_vld_s;

endmodule : pump_pick

// File: rtl/pump_bank_ctrl.sv
// -----------------------------------------------------------------------------
// pump_bank_ctrl
// Sequential controller for a bank of drain pumps on one sump. The lead pump
// starts on high level, further pumps are staged in while high level persists,
// everything stops on low level once the minimum run time is met, and the lead
// rotates after every completed pump-down. Faulted pumps are skipped.
//   clk        in  1          system clock
//   reset      in  1          synchronous, active-high reset
//   lvl_low    in  1          1 = water at/above low sensor
//   lvl_high   in  1          1 = water at/above high sensor
//   pump_fault in  N_PUMPS    1 = pump i unavailable
//   pump_on    out N_PUMPS    registered run command per pump
//   lead_idx   out IDX_W      current lead pump
//   n_active   out IDX_W+1    number of pumps currently commanded on
//   alarm      out 1          sensor inconsistency / no healthy pump available
// -----------------------------------------------------------------------------
module pump_bank_ctrl
    import pump_bank_ctrl_pkg::*;
#(
    parameter  int N_PUMPS     = 2,
    parameter  int STAGE_DELAY = 16,
    parameter  int MIN_ON      = 8,
    localparam int IDX_W       = $clog2(N_PUMPS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               lvl_low,
    input  logic               lvl_high,
    input  logic [N_PUMPS-1:0] pump_fault,
    output logic [N_PUMPS-1:0] pump_on,
    output logic [IDX_W-1:0]   lead_idx,
    output logic [IDX_W:0]     n_active,
    output logic               alarm
);

    localparam int STAGE_W = $clog2(STAGE_DELAY + 1);
    localparam int RUN_W   = $clog2(MIN_ON + 1);

    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(STAGE_DELAY - 1);
    localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(MIN_ON - 1);

    pump_state_e        state_r,     state_s;
    logic [N_PUMPS-1:0] pump_on_r,   pump_on_s;
    logic [IDX_W-1:0]   lead_idx_r,  lead_idx_s;
    logic [IDX_W-1:0]   last_add_r,  last_add_s;
    logic [STAGE_W-1:0] stage_cnt_r, stage_cnt_s;
    logic [RUN_W-1:0]   run_cnt_r,   run_cnt_s;
    logic               alarm_r,     alarm_s;
    logic [IDX_W:0]     n_active_r,  n_active_s;

    logic [N_PUMPS-1:0] healthy_s;
    logic [N_PUMPS-1:0] running_ok_s;
    logic               sens_err_s;
    logic [IDX_W-1:0]   lead_pick_s, rot_pick_s, stg_pick_s;
    logic               lead_vld_s,  rot_vld_s,  stg_vld_s;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(N_PUMPS - 1)) begin
            return {IDX_W{1'b0}};
        end else begin
            return idx + IDX_W'(1'b1);
        end
    endfunction

    function automatic logic [N_PUMPS-1:0] idx_to_mask(input logic [IDX_W-1:0] idx);
        logic [N_PUMPS-1:0] m;
        m      = {N_PUMPS{1'b0}};
        m[idx] = 1'b1;
        return m;
    endfunction

    assign healthy_s    = ~pump_fault;
    assign running_ok_s = pump_on_r & healthy_s;
    assign sens_err_s   = lvl_high & ~lvl_low;

    // Lead selection and re-pick: first healthy pump from the lead, inclusive.
    pump_pick #(.N_PUMPS(N_PUMPS)) u_pick_lead (
        .mask      (healthy_s),
        .start_idx (lead_idx_r),
        .excl_mask ({N_PUMPS{1'b0}}),
        .pick_idx  (lead_pick_s),
        .pick_vld  (lead_vld_s)
    );

    // Rotation: first healthy pump strictly after the current lead.
    pump_pick #(.N_PUMPS(N_PUMPS)) u_pick_rot (
        .mask      (healthy_s),
        .start_idx (next_idx(lead_idx_r)),
        .excl_mask ({N_PUMPS{1'b0}}),
        .pick_idx  (rot_pick_s),
        .pick_vld  (rot_vld_s)
    );

    // Staging: next healthy, not-yet-running pump after the last one added.
    pump_pick #(.N_PUMPS(N_PUMPS)) u_pick_stage (
        .mask      (healthy_s),
        .start_idx (next_idx(last_add_r)),
        .excl_mask (pump_on_r),
        .pick_idx  (stg_pick_s),
        .pick_vld  (stg_vld_s)
    );

    // Next-state, next-output and timer logic for the controller.
    always_comb begin
        state_s     = state_r;
        pump_on_s   = pump_on_r;
        lead_idx_s  = lead_idx_r;
        last_add_s  = last_add_r;
        stage_cnt_s = stage_cnt_r;
        run_cnt_s   = run_cnt_r;
        alarm_s     = alarm_r;

        case (state_r)
            ST_IDLE: begin
                pump_on_s   = {N_PUMPS{1'b0}};
                stage_cnt_s = {STAGE_W{1'b0}};
                run_cnt_s   = {RUN_W{1'b0}};
                if (sens_err_s) begin
                    state_s = ST_SENS_ERR;
                    alarm_s = 1'b1;
                end else if (lvl_high && lvl_low) begin
                    state_s = ST_PUMP;
                    if (lead_vld_s) begin
                        pump_on_s  = idx_to_mask(lead_pick_s);
                        lead_idx_s = lead_pick_s;
                        last_add_s = lead_pick_s;
                        alarm_s    = 1'b0;
                    end else begin
                        // Demand with every pump faulted: enter PUMP dark and alarm.
                        alarm_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_PUMP: begin
                if (run_cnt_r != {RUN_W{1'b1}}) begin
                    run_cnt_s = run_cnt_r + RUN_W'(1'b1);
                end else begin
                    run_cnt_s = run_cnt_r;
                end

                if (sens_err_s) begin
                    state_s     = ST_SENS_ERR;
                    pump_on_s   = {N_PUMPS{1'b0}};
                    alarm_s     = 1'b1;
                    stage_cnt_s = {STAGE_W{1'b0}};
                    run_cnt_s   = {RUN_W{1'b0}};
                end else if (!lvl_low && (run_cnt_r >= RUN_LAST)) begin
                    // Completed pump-down: stop everything and rotate the lead.
                    state_s     = ST_IDLE;
                    pump_on_s   = {N_PUMPS{1'b0}};
                    stage_cnt_s = {STAGE_W{1'b0}};
                    run_cnt_s   = {RUN_W{1'b0}};
                    if (rot_vld_s) begin
                        lead_idx_s = rot_pick_s;
                    end else begin
                        lead_idx_s = lead_idx_r;
                    end
                end else if (running_ok_s == {N_PUMPS{1'b0}}) begin
                    // Nothing healthy left running: re-pick in the same cycle.
                    stage_cnt_s = {STAGE_W{1'b0}};
                    if (lead_vld_s) begin
                        pump_on_s  = idx_to_mask(lead_pick_s);
                        lead_idx_s = lead_pick_s;
                        last_add_s = lead_pick_s;
                        alarm_s    = 1'b0;
                    end else begin
                        pump_on_s = {N_PUMPS{1'b0}};
                        alarm_s   = 1'b1;
                    end
                end else if (running_ok_s != pump_on_r) begin
                    // A running pump faulted; dropping it takes priority over staging.
                    pump_on_s   = running_ok_s;
                    stage_cnt_s = {STAGE_W{1'b0}};
                end else if (lvl_high && lvl_low) begin
                    if (stage_cnt_r >= STAGE_LAST) begin
                        stage_cnt_s = {STAGE_W{1'b0}};
                        if (stg_vld_s) begin
                            pump_on_s  = pump_on_r | idx_to_mask(stg_pick_s);
                            last_add_s = stg_pick_s;
                        end else begin
                            pump_on_s = pump_on_r;
                        end
                    end else begin
                        stage_cnt_s = stage_cnt_r + STAGE_W'(1'b1);
                    end
                end else begin
                    // High level gone, or waiting out the minimum run time.
                    stage_cnt_s = {STAGE_W{1'b0}};
                end
            end

            ST_SENS_ERR: begin
                pump_on_s   = {N_PUMPS{1'b0}};
                stage_cnt_s = {STAGE_W{1'b0}};
                run_cnt_s   = {RUN_W{1'b0}};
                if (sens_err_s) begin
                    state_s = ST_SENS_ERR;
                    alarm_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                    alarm_s = 1'b0;
                end
            end

            default: begin
                state_s     = ST_IDLE;
                pump_on_s   = {N_PUMPS{1'b0}};
                stage_cnt_s = {STAGE_W{1'b0}};
                run_cnt_s   = {RUN_W{1'b0}};
                alarm_s     = 1'b1;
            end
        endcase
    end

    // Population count of the next run command, registered alongside it.
    always_comb begin
        n_active_s = {(IDX_W+1){1'b0}};
        for (int i = 0; i < N_PUMPS; i++) begin
            n_active_s = n_active_s + {{IDX_W{1'b0}}, pump_on_s[i]};
        end
    end

    // State, outputs and timers, with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            pump_on_r   <= {N_PUMPS{1'b0}};
            lead_idx_r  <= {IDX_W{1'b0}};
            last_add_r  <= {IDX_W{1'b0}};
            stage_cnt_r <= {STAGE_W{1'b0}};
            run_cnt_r   <= {RUN_W{1'b0}};
            alarm_r     <= 1'b0;
            n_active_r  <= {(IDX_W+1){1'b0}};
        end else begin
            state_r     <= state_s;
            pump_on_r   <= pump_on_s;
            lead_idx_r  <= lead_idx_s;
            last_add_r  <= last_add_s;
            stage_cnt_r <= stage_cnt_s;
            run_cnt_r   <= run_cnt_s;
            alarm_r     <= alarm_s;
            n_active_r  <= n_active_s;
        end
    end

    assign pump_on  = pump_on_r;
    assign lead_idx = lead_idx_r;
    assign n_active = n_active_r;
    assign alarm    = alarm_r;

endmodule : pump_bank_ctrl

// File: tb/tb_pump_bank_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pump_bank_ctrl
// Directed bench for pump_bank_ctrl with N_PUMPS=2, STAGE_DELAY=4, MIN_ON=3.
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after the
// following rising edge.
// -----------------------------------------------------------------------------
module tb_pump_bank_ctrl;

    logic       clk;
    logic       reset;
    logic       lvl_low;
    logic       lvl_high;
    logic [1:0] pump_fault;
    logic [1:0] pump_on;
    logic [0:0] lead_idx;
    logic [1:0] n_active;
    logic       alarm;

    int n_cmp = 0;
    int n_mis = 0;

    pump_bank_ctrl #(
        .N_PUMPS     (2),
        .STAGE_DELAY (4),
        .MIN_ON      (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .lvl_low    (lvl_low),
        .lvl_high   (lvl_high),
        .pump_fault (pump_fault),
        .pump_on    (pump_on),
        .lead_idx   (lead_idx),
        .n_active   (n_active),
        .alarm      (alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [1:0] e_on, input logic e_lead,
                             input logic [1:0] e_n, input logic e_alarm);
        check_val({tag, ".pump_on"},  32'(pump_on),  32'(e_on));
        check_val({tag, ".lead_idx"}, 32'(lead_idx), 32'(e_lead));
        check_val({tag, ".n_active"}, 32'(n_active), 32'(e_n));
        check_val({tag, ".alarm"},    32'(alarm),    32'(e_alarm));
    endtask

    initial begin
        reset      = 1'b1;
        lvl_low    = 1'b0;
        lvl_high   = 1'b0;
        pump_fault = 2'b00;

        // Reset held for two cycles.
        step();
        step();
        check_all("reset", 2'b00, 1'b0, 2'd0, 1'b0);
        reset = 1'b0;
        step();
        check_all("idle", 2'b00, 1'b0, 2'd0, 1'b0);

        // Demand: lead 0 starts, second pump staged after STAGE_DELAY.
        lvl_low  = 1'b1;
        lvl_high = 1'b1;
        step();
        check_all("start", 2'b01, 1'b0, 2'd1, 1'b0);
        step();
        step();
        step();
        check_val("stage_t3.pump_on", 32'(pump_on), 32'(2'b01));
        step();
        check_all("stage_t4", 2'b11, 1'b0, 2'd2, 1'b0);

        // Pump-down completes, lead rotates to 1.
        lvl_high = 1'b0;
        step();
        check_val("hi_drop.pump_on", 32'(pump_on), 32'(2'b11));
        lvl_low = 1'b0;
        step();
        check_all("stop", 2'b00, 1'b1, 2'd0, 1'b0);

        // Next demand starts the new lead; low drops one cycle later (MIN_ON).
        lvl_low  = 1'b1;
        lvl_high = 1'b1;
        step();
        check_all("rot_start", 2'b10, 1'b1, 2'd1, 1'b0);
        lvl_low  = 1'b0;
        lvl_high = 1'b0;
        step();
        check_val("minon_1.pump_on", 32'(pump_on), 32'(2'b10));
        step();
        check_val("minon_2.pump_on", 32'(pump_on), 32'(2'b10));
        step();
        check_all("minon_stop", 2'b00, 1'b0, 2'd0, 1'b0);

        // Faults: lead faulted -> other pump; all faulted -> alarm; recovery.
        lvl_low  = 1'b1;
        lvl_high = 1'b1;
        step();
        check_all("f_start", 2'b01, 1'b0, 2'd1, 1'b0);
        lvl_high   = 1'b0;
        pump_fault = 2'b01;
        step();
        check_all("f_lead", 2'b10, 1'b1, 2'd1, 1'b0);
        pump_fault = 2'b11;
        step();
        check_all("f_all", 2'b00, 1'b1, 2'd0, 1'b1);
        pump_fault = 2'b10;
        step();
        check_all("f_recover", 2'b01, 1'b0, 2'd1, 1'b0);
        pump_fault = 2'b00;

        // Sensor inconsistency during PUMP, then recovery to IDLE.
        lvl_high = 1'b1;
        lvl_low  = 1'b0;
        step();
        check_all("sens_err", 2'b00, 1'b0, 2'd0, 1'b1);
        lvl_high = 1'b0;
        step();
        check_all("sens_ok", 2'b00, 1'b0, 2'd0, 1'b0);

        // Demand with every pump faulted, then one recovers.
        pump_fault = 2'b11;
        lvl_low    = 1'b1;
        lvl_high   = 1'b1;
        step();
        check_all("dark_start", 2'b00, 1'b0, 2'd0, 1'b1);
        pump_fault = 2'b00;
        step();
        check_all("dark_recover", 2'b01, 1'b0, 2'd1, 1'b0);

        // Reset mid-pumping stops everything on the next edge.
        reset = 1'b1;
        step();
        check_all("reset_mid", 2'b00, 1'b0, 2'd0, 1'b0);
        reset    = 1'b0;
        lvl_low  = 1'b0;
        lvl_high = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_pump_bank_ctrl
